// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard interface: decode-side inputs to the hazard controller
// and the stall, flush, issue and forwarding-tag outputs it returns.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_ir;
    logic             id_valid;
    logic             branch_taken;
    logic             mem_busy;
    logic             issue;
    logic             stall;
    logic             flush;
    logic [4:0]       AA;
    logic [4:0]       AM;
    logic [4:0]       AW;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_ir, id_valid, branch_taken, mem_busy,
        input  issue, stall, flush, AA, AM, AW, bubble_cnt
    );

    modport slave (
        input  id_ir, id_valid, branch_taken, mem_busy,
        output issue, stall, flush, AA, AM, AW, bubble_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for execute and later stages: tracks in-flight destination
// registers, drives forwarding tags, detects load-use and sequences branch flushes.
module hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [1:0] LAST_K   = 2'(FLUSH_CYCLES - 1);

    // rd is stored already masked by wr, so a valid entry's rd is its tag.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       ld;
    } entry_t;

    typedef enum logic {IDLE, FLUSH} state_t;

    entry_t           ex_q, mem_q, wb_q;
    state_t           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [CNT_W-1:0] bubble_q;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       wr, use1, use2, ld, load_use;
    logic       flush, stall, issue;
    logic       unused_ir;

    assign opcode    = hz.id_ir[6:0];
    assign rd        = hz.id_ir[11:7];
    assign rs1       = hz.id_ir[19:15];
    assign rs2       = hz.id_ir[24:20];
    assign unused_ir = ^{hz.id_ir[31:25], hz.id_ir[14:12]};

    assign wr   = opcode inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    assign use1 = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR};
    assign use2 = opcode inside {OP_R, OP_STORE, OP_BR};
    assign ld   = (opcode == OP_LOAD);

    assign load_use = ex_q.valid && ex_q.ld && (ex_q.rd != 5'd0) &&
                      ((use1 && rs1 == ex_q.rd) || (use2 && rs2 == ex_q.rd));

    assign stall = hz.mem_busy | load_use;
    assign issue = hz.id_valid & ~stall & ~flush;

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        flush   = hz.branch_taken | (state_q != IDLE);
        if (!hz.mem_busy) begin
            case (state_q)
                IDLE: begin
                    if (hz.branch_taken && FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        k_d     = 2'd1;
                    end
                end
                FLUSH: begin
                    if (k_q == LAST_K) begin
                        state_d = IDLE;
                        k_d     = 2'd0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; WB <= MEM <= EX shifts correctly in any order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else if (!hz.mem_busy) begin
            state_q <= state_d;
            k_q     <= k_d;
            wb_q    <= mem_q;
            mem_q   <= '{valid: ex_q.valid & ~flush, rd: ex_q.rd, ld: ex_q.ld};
            ex_q    <= issue ? '{valid: 1'b1, rd: (wr ? rd : 5'd0), ld: ld} : '0;
        end
    end

    // Counts stalled decode cycles even while memory freezes the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (hz.id_valid && !issue && bubble_q != '1) begin
            bubble_q <= bubble_q + 1'b1;
        end
    end

    assign hz.issue      = issue;
    assign hz.stall      = stall;
    assign hz.flush      = flush;
    assign hz.AA         = ex_q.valid  ? ex_q.rd  : 5'd0;
    assign hz.AM         = mem_q.valid ? mem_q.rd : 5'd0;
    assign hz.AW         = wb_q.valid  ? wb_q.rd  : 5'd0;
    assign hz.bubble_cnt = bubble_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: forwarding tags, load-use stall,
// branch flush sequencing, memory freeze and asynchronous reset mid-flush.
module tb_hazard_ctrl;
    localparam int CNT_W = 16;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic v, input logic bt, input logic busy);
        hz.id_ir        = ir;
        hz.id_valid     = v;
        hz.branch_taken = bt;
        hz.mem_busy     = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tags(input string tag, input logic [4:0] a, input logic [4:0] m, input logic [4:0] w);
        check({tag, ".AA"}, 32'(hz.AA), 32'(a));
        check({tag, ".AM"}, 32'(hz.AM), 32'(m));
        check({tag, ".AW"}, 32'(hz.AW), 32'(w));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with a taken branch offered while in reset
        drive(mk(OP_I, 5'd3, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        #10;
        tags("reset", 5'd0, 5'd0, 5'd0);
        check("reset.bubble", 32'(hz.bubble_cnt), 0);
        check("reset.flush", 32'(hz.flush), 1);
        check("reset.issue", 32'(hz.issue), 0);
        check("reset.stall", 32'(hz.stall), 0);
        rst = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Back-to-back ALU: ADDI x3 then ADD x4,x3,x3
        drive(mk(OP_I, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        check("alu.issue0", 32'(hz.issue), 1);
        tick();
        check("alu.AA0", 32'(hz.AA), 3);
        drive(mk(OP_R, 5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b0);
        check("alu.stall1", 32'(hz.stall), 0);
        check("alu.issue1", 32'(hz.issue), 1);
        tick();
        tags("alu.c1", 5'd4, 5'd3, 5'd0);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tags("alu.c2", 5'd0, 5'd4, 5'd3);

        // Load-use: LW x7 then ADD x8,x7,x1
        drive(mk(OP_LOAD, 5'd7, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
        check("lu.issue_lw", 32'(hz.issue), 1);
        tick();
        drive(mk(OP_R, 5'd8, 5'd7, 5'd1), 1'b1, 1'b0, 1'b0);
        check("lu.stall", 32'(hz.stall), 1);
        check("lu.issue_blocked", 32'(hz.issue), 0);
        tick();
        check("lu.bubble", 32'(hz.bubble_cnt), 1);
        tags("lu.after", 5'd0, 5'd7, 5'd0);
        check("lu.stall_gone", 32'(hz.stall), 0);
        check("lu.issue_add", 32'(hz.issue), 1);
        tick();
        tags("lu.add_in_ex", 5'd8, 5'd0, 5'd7);
        check("lu.bubble_hold", 32'(hz.bubble_cnt), 1);

        // Store and branch carry no destination tag
        drive(mk(OP_STORE, 5'd4, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        check("sb.issue_sw", 32'(hz.issue), 1);
        tick();
        check("sb.AA_sw", 32'(hz.AA), 0);
        drive(mk(OP_BR, 5'd8, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        check("sb.issue_beq", 32'(hz.issue), 1);
        tick();
        check("sb.AA_beq", 32'(hz.AA), 0);
        check("sb.AM_sw", 32'(hz.AM), 0);

        // Writes to x0: LW x0 then ADD x1,x0,x0
        drive(mk(OP_LOAD, 5'd0, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
        check("x0.AA_lw", 32'(hz.AA), 0);
        drive(mk(OP_R, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        check("x0.stall", 32'(hz.stall), 0);
        check("x0.issue", 32'(hz.issue), 1);
        tick();
        check("x0.AA_add", 32'(hz.AA), 1);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tags("drain", 5'd0, 5'd0, 5'd0);

        // Taken branch: BEQ in MEM, ADD x9 in EX, ADDI x10 in ID
        drive(mk(OP_BR, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        drive(mk(OP_R, 5'd9, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        tags("br.setup", 5'd9, 5'd0, 5'd0);
        drive(mk(OP_I, 5'd10, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        check("br.flush0", 32'(hz.flush), 1);
        check("br.issue0", 32'(hz.issue), 0);
        tick();
        tags("br.killed", 5'd0, 5'd0, 5'd0);
        check("br.bubble1", 32'(hz.bubble_cnt), 2);
        // second pulse while flushing must not extend the flush
        drive(mk(OP_I, 5'd10, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        check("br.flush1", 32'(hz.flush), 1);
        check("br.issue1", 32'(hz.issue), 0);
        tick();
        check("br.AM_not9", 32'(hz.AM), 0);
        check("br.bubble2", 32'(hz.bubble_cnt), 3);
        drive(mk(OP_I, 5'd10, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        check("br.flush_done", 32'(hz.flush), 0);
        check("br.issue_resume", 32'(hz.issue), 1);
        tick();
        check("br.AA10", 32'(hz.AA), 10);
        check("br.bubble3", 32'(hz.bubble_cnt), 3);

        // Memory freeze with EX/MEM/WB = x1/x2/x3
        drive(mk(OP_I, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
        drive(mk(OP_I, 5'd2, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
        drive(mk(OP_I, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
        tags("busy.setup", 5'd1, 5'd2, 5'd3);
        drive(mk(OP_I, 5'd11, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1);
        check("busy.stall", 32'(hz.stall), 1);
        check("busy.issue", 32'(hz.issue), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            tags($sformatf("busy.hold%0d", i), 5'd1, 5'd2, 5'd3);
            check($sformatf("busy.bubble%0d", i), 32'(hz.bubble_cnt), 32'(3 + i));
        end
        drive(mk(OP_I, 5'd11, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        check("busy.release_issue", 32'(hz.issue), 1);
        tick();
        tags("busy.shift1", 5'd11, 5'd1, 5'd2);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tags("busy.shift2", 5'd0, 5'd11, 5'd1);

        // Reset in the middle of a flush
        drive(mk(OP_R, 5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        check("rmf.AA5", 32'(hz.AA), 5);
        drive(mk(OP_I, 5'd12, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        tick();
        check("rmf.bubble7", 32'(hz.bubble_cnt), 7);
        drive(mk(OP_I, 5'd12, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        check("rmf.in_flush", 32'(hz.flush), 1);
        #2;
        rst = 1'b1;
        #1;
        tags("rmf.reset", 5'd0, 5'd0, 5'd0);
        check("rmf.bubble0", 32'(hz.bubble_cnt), 0);
        check("rmf.flush_idle", 32'(hz.flush), 0);
        rst = 1'b0;
        check("rmf.issue_now", 32'(hz.issue), 1);
        tick();
        check("rmf.AA12", 32'(hz.AA), 12);
        check("rmf.bubble_after", 32'(hz.bubble_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
